answer_checker: RTL
===================

Name: answer_checker

Overview:
- Listening side of the scale game. The tone player drives expected notes into this block while the buzzer sounds them.
- The block then debounces the seven note buttons, encodes each press to a note code and compares presses in order against the stored sequence.
- It reports pass/fail to the game controller and exposes the last two entered notes for the display.

Parameters:
- DEB_CYC, 500000: cycles a raw key must be stable before its debounced level changes (10 ms at 50 MHz).
- MAX_LEN, 8: maximum stored sequence length.
- TIMEOUT_CYC, 250000000: idle cycles allowed between presses in ANSWER before fail (5 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear buffers, begin a new round (enter LOAD)
- exp_we  in  1  write strobe for an expected note, one note per asserted cycle
- exp_note  in  4  expected note code, 1..7 = do..si
- exp_done  in  1  pulse: player finished the sequence
- key_raw  in  7  raw buttons, active-high; bit i = note i+1
- busy  out  1  high in LOAD or ANSWER
- entered_cnt  out  4  correct notes entered this round
- key_buf  out  6  {previous note[2:0], last note[2:0]}; 0 = none
- pass  out  1  one-cycle pulse, whole sequence matched
- fail  out  1  one-cycle pulse, mismatch, timeout or empty sequence
- result_ok  out  1  latched pass; cleared on start or reset
- result_bad  out  1  latched fail; cleared on start or reset

Behaviour:
- Reset: every output 0, FSM in IDLE, pointers/length/debounce/timeout counters 0, note memory contents don't-care.
- Debounce, per key: per-key counter. Raw sample differs from debounced level → count; at DEB_CYC consecutive differing cycles, debounced level flips and counter clears. Any cycle where the sample equals the level clears the counter.
- Press event: rising edge of a debounced key, registered, so one cycle after the debounced flip.
- Several keys rising in the same cycle: only the lowest index counts; the others are dropped.
- Note code = index+1 (3-bit value, zero-extended to 4 for comparison).
- Debouncers run in every state. Press events are acted on only in ANSWER.
- FSM states: IDLE, LOAD, ANSWER, RESULT. start takes priority over every other input in every state.
- IDLE: start → LOAD.
- LOAD: on start, clear len, wr_ptr, rd_ptr, entered_cnt, key_buf, result_ok, result_bad.
  - exp_we: mem[wr_ptr] ← exp_note and len++ while len < MAX_LEN. Extra writes are discarded silently.
  - exp_done with len > 0 → ANSWER, timeout counter cleared.
  - exp_done with len = 0 → fail pulse, result_bad = 1, → RESULT.
  - exp_we and exp_done in the same cycle: the write completes, then the transition uses the updated len.
- ANSWER, on a press with note n:
  - key_buf ← {key_buf[2:0], n}.
  - n ≠ mem[rd_ptr] → fail pulse next cycle, result_bad = 1, → RESULT.
  - Match → rd_ptr++, entered_cnt++. If rd_ptr+1 = len: pass pulse, result_ok = 1, → RESULT.
  - The timeout counter clears on each press. When it reaches TIMEOUT_CYC with no press → fail, result_bad = 1, → RESULT.
  - Stored codes outside 1..7 never match, so a press at that position fails.
- RESULT: flags, key_buf and entered_cnt hold. Presses are ignored. start → LOAD (clears flags). exp_we/exp_done are ignored.
- pass and fail are never high in the same cycle. Each fires exactly once per round.
- Reset mid-round: everything returns to the reset state, and any pending press event is discarded.
- Widths: len, wr_ptr, rd_ptr use clog2(MAX_LEN)+1 bits. Debounce counter uses clog2(DEB_CYC+1) bits. Timeout counter uses clog2(TIMEOUT_CYC+1) bits.

Decomposition:
- Shared package: note-code constants (NOTE_NONE = 0, NOTE_DO = 1 … NOTE_SI = 7), FSM state encoding, MAX_LEN default.
- Sub-module key_debounce: one instance per key, with DEB_CYC as parameter. Output is the debounced level plus a one-cycle rise pulse.
- Encoder, note memory and FSM stay in answer_checker.

Test Plan (DEB_CYC=4, TIMEOUT_CYC=100, MAX_LEN=8):
- Load and match: start; write 3,5,1; exp_done; press key bits 2,4,0, each held 10 cycles → entered_cnt 1,2,3; one pass pulse; result_ok=1; key_buf=3'd5,3'd1 (0x29); busy=0.
- Mismatch: load 2,2; press bit 1 then bit 3 → entered_cnt=1; fail pulse exactly one cycle after the second press event; result_bad=1; key_buf = {2,4}.
- Bounce filtering: toggle key bit 0 high/low every 2 cycles for 20 cycles, then hold high → exactly one press event, 5 cycles after the final rise (4 debounce + 1 register).
- Overflow and simultaneity: write 10 notes of 7 → len=8. Press bits 6 and 0 together → note 1 taken → fail.
- Timeout and empty: after exp_done with len 2 and no press, fail at cycle 100. Separately, start then exp_done with no writes → immediate fail, state RESULT.
- Reset mid-ANSWER after one correct press → all outputs 0, state IDLE; a press in IDLE produces no pass/fail.

Source files
------------

// File: rtl/answer_checker_pkg.sv
// Shared definitions for the scale-game answer checker: note codes,
// FSM state encoding and the default sequence depth.
package answer_checker_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned NUM_KEYS    = 7;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SOL  = 3'd5;
  localparam logic [2:0] NOTE_LA   = 3'd6;
  localparam logic [2:0] NOTE_SI   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ANSWER,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/answer_checker_key_debounce.sv
// Single-key debouncer: the level flips after DEB_CYC consecutive samples
// that disagree with it; rise_o pulses for one cycle as the level goes high.
module key_debounce #(
  parameter int unsigned DEB_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (raw_i != level_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/answer_checker.sv
// Listening side of the scale game: stores the expected note sequence,
// debounces the note keys and grades the player's presses in order.
module answer_checker
  import answer_checker_pkg::*;
#(
  parameter int unsigned DEB_CYC     = 500000,
  parameter int unsigned MAX_LEN     = MAX_LEN_DEF,
  parameter int unsigned TIMEOUT_CYC = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       exp_we,
  input  logic [3:0] exp_note,
  input  logic       exp_done,
  input  logic [6:0] key_raw,
  output logic       busy,
  output logic [3:0] entered_cnt,
  output logic [5:0] key_buf,
  output logic       pass,
  output logic       fail,
  output logic       result_ok,
  output logic       result_bad
);

  localparam int unsigned LW = $clog2(MAX_LEN) + 1;
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [NUM_KEYS-1:0] deb_level, deb_rise, key_rise;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (key_raw[g]),
      .level_o(deb_level[g]),
      .rise_o (deb_rise[g])
    );
  end

  assign key_rise = deb_rise & deb_level;

  // Lowest-index key wins when several rise together.
  logic       enc_vld;
  logic [2:0] enc_note;
  always_comb begin
    enc_vld  = 1'b0;
    enc_note = NOTE_NONE;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key_rise[i] && !enc_vld) begin
        enc_vld  = 1'b1;
        enc_note = 3'(i + 1);
      end
    end
  end

  logic          press_vld_q;
  logic [2:0]    press_note_q;
  logic [3:0]    mem_q [MAX_LEN];
  logic          mem_we;
  logic [AW-1:0] rd_idx;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    entered_q, entered_d;
  logic [5:0]    key_buf_q, key_buf_d;
  logic          pass_q, pass_d, fail_q, fail_d;
  logic          ok_q, ok_d, bad_q, bad_d;

  assign rd_idx = rd_ptr_q[AW-1:0];

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    to_cnt_d  = to_cnt_q;
    entered_d = entered_q;
    key_buf_d = key_buf_q;
    ok_d      = ok_q;
    bad_d     = bad_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    mem_we    = 1'b0;

    if (start) begin
      state_d   = ST_LOAD;
      len_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      entered_d = '0;
      key_buf_d = '0;
      ok_d      = 1'b0;
      bad_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (exp_we && (wr_ptr_q < LW'(MAX_LEN))) begin
            mem_we   = 1'b1;
            len_d    = len_q + LW'(1);
            wr_ptr_d = wr_ptr_q + LW'(1);
          end
          // A same-cycle write is already reflected in len_d here.
          if (exp_done) begin
            if (len_d != '0) begin
              state_d  = ST_ANSWER;
              to_cnt_d = '0;
            end else begin
              fail_d  = 1'b1;
              bad_d   = 1'b1;
              state_d = ST_RESULT;
            end
          end
        end
        ST_ANSWER: begin
          if (press_vld_q) begin
            key_buf_d = {key_buf_q[2:0], press_note_q};
            to_cnt_d  = '0;
            if ({1'b0, press_note_q} != mem_q[rd_idx]) begin
              fail_d  = 1'b1;
              bad_d   = 1'b1;
              state_d = ST_RESULT;
            end else begin
              rd_ptr_d  = rd_ptr_q + LW'(1);
              entered_d = entered_q + 4'd1;
              if ((rd_ptr_q + LW'(1)) == len_q) begin
                pass_d  = 1'b1;
                ok_d    = 1'b1;
                state_d = ST_RESULT;
              end
            end
          end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            fail_d  = 1'b1;
            bad_d   = 1'b1;
            state_d = ST_RESULT;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        ST_RESULT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      to_cnt_q     <= '0;
      entered_q    <= '0;
      key_buf_q    <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      ok_q         <= 1'b0;
      bad_q        <= 1'b0;
      press_vld_q  <= 1'b0;
      press_note_q <= NOTE_NONE;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      to_cnt_q     <= to_cnt_d;
      entered_q    <= entered_d;
      key_buf_q    <= key_buf_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      ok_q         <= ok_d;
      bad_q        <= bad_d;
      press_vld_q  <= enc_vld;
      press_note_q <= enc_note;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= exp_note;
  end

  assign busy        = (state_q == ST_LOAD) || (state_q == ST_ANSWER);
  assign entered_cnt = entered_q;
  assign key_buf     = key_buf_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign result_ok   = ok_q;
  assign result_bad  = bad_q;

endmodule
